// File: rtl/reset_seq_pkg.sv
// Shared types for the reset sequencer: FSM state encoding and a width helper.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ASSERT = 2'd0,
        STEP   = 2'd1,
        DONE   = 2'd2
    } seq_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Control/status bundle between the reset sequencer (slave) and its environment (master).
interface reset_sequencer_if #(
    parameter int NUM_OUTPUTS = 4
);
    import reset_seq_pkg::*;

    // stage_ready[k] is a level, not a pulse: once domain k is released, the
    // sequencer releases domain k+1 only while stage_ready[k] is high (or on timeout).
    logic                   soft_reset_req;
    logic [NUM_OUTPUTS-1:0] stage_ready;
    logic [NUM_OUTPUTS-1:0] rst_n_out;
    logic                   all_released;
    logic                   busy;
    logic                   timeout_err;
    seq_state_e             state;

    modport master (
        output soft_reset_req, stage_ready,
        input  rst_n_out, all_released, busy, timeout_err, state
    );

    modport slave (
        input  soft_reset_req, stage_ready,
        output rst_n_out, all_released, busy, timeout_err, state
    );

endinterface

// File: rtl/reset_sync_chain.sv
// Async-assert, sync-deassert reset synchroniser with configurable depth.
module reset_sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    output logic rst_sync
);

    logic [SYNC_STAGES-1:0] chain_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chain_q <= '1;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign rst_sync = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Stretches a synchronised reset, then releases NUM_OUTPUTS domain resets in
// order, each gated by a step delay and the previous domain's ready (or a timeout).
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_OUTPUTS    = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int STRETCH_CYCLES = 16,
    parameter int STEP_CYCLES    = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clock,
    input  logic              reset,
    reset_sequencer_if.slave  bus
);

    localparam int MAX_CYC = (STRETCH_CYCLES > TIMEOUT_CYCLES) ? STRETCH_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = clog2(MAX_CYC + 1);
    localparam int IDX_W   = clog2(NUM_OUTPUTS) + 1;

    logic                   rst_sync;
    seq_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_OUTPUTS-1:0] rst_n_q, rst_n_d;
    logic                   err_q, err_d;
    logic                   all_rel_q;
    logic                   busy_q;
    logic                   ready_sel;
    logic                   step_ok;
    logic                   timed_out;

    reset_sync_chain #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clock    (clock),
        .reset    (reset),
        .rst_sync (rst_sync)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ASSERT;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_n_q   <= '0;
            err_q     <= 1'b0;
            all_rel_q <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rst_n_q   <= rst_n_d;
            err_q     <= err_d;
            all_rel_q <= &rst_n_d;
            busy_q    <= ~(&rst_n_d);
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rst_n_d   = rst_n_q;
        err_d     = err_q;
        ready_sel = 1'b0;
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
            if (IDX_W'(k) == idx_q) ready_sel = bus.stage_ready[k];
        end
        step_ok   = (cnt_q >= CNT_W'(STEP_CYCLES - 1)) && ready_sel;
        timed_out = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

        // Soft reset outranks any release scheduled for the same edge.
        if (rst_sync || bus.soft_reset_req) begin
            state_d = ASSERT;
            cnt_d   = '0;
            idx_d   = '0;
            rst_n_d = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ASSERT: begin
                    if (cnt_q == CNT_W'(STRETCH_CYCLES - 1)) begin
                        rst_n_d[0] = 1'b1;
                        idx_d      = '0;
                        cnt_d      = '0;
                        state_d    = (NUM_OUTPUTS > 1) ? STEP : DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STEP: begin
                    if (step_ok || timed_out) begin
                        for (int k = 1; k < NUM_OUTPUTS; k++) begin
                            if (IDX_W'(k) == idx_q + 1'b1) rst_n_d[k] = 1'b1;
                        end
                        idx_d = idx_q + 1'b1;
                        cnt_d = '0;
                        if (!step_ok) err_d = 1'b1;
                        if (idx_q + 1'b1 == IDX_W'(NUM_OUTPUTS - 1)) state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = ASSERT;
                end
            endcase
        end
    end

    always_comb begin
        bus.rst_n_out    = rst_n_q;
        bus.all_released = all_rel_q;
        bus.busy         = busy_q;
        bus.timeout_err  = err_q;
        bus.state        = state_q;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Parametrised reset controller for the fabric.
- Synchronises one asynchronous, active-high reset input with a depth-configurable flop chain.
- Stretches the reset to a minimum width, then releases NUM_OUTPUTS active-low domain resets one after another.
- Each release waits for a step delay and for a ready handshake from the previous domain.
- Adds a synchronous soft-reset request, a per-stage timeout with a sticky error flag, and status outputs.

Parameters:
NUM_OUTPUTS, 4, number of sequenced reset outputs (1..16)
SYNC_STAGES, 2, synchroniser flop depth (>=2)
STRETCH_CYCLES, 16, clocks reset is held after synchronised deassertion (>=1)
STEP_CYCLES, 8, minimum clocks between successive releases (>=1)
TIMEOUT_CYCLES, 256, clocks to wait for stage_ready before forcing the next release (>STEP_CYCLES)

Ports:
clock  in  1  single clock; all logic is on its rising edge
reset  in  1  asynchronous, active-high reset; assertion is asynchronous, deassertion is synchronised internally
soft_reset_req  in  1  synchronous pulse; restarts the full sequence
stage_ready  in  NUM_OUTPUTS  bit k: domain k is up after its release; the caller synchronises it to clock
rst_n_out  out  NUM_OUTPUTS  active-low domain resets; bit 0 is released first
all_released  out  1  high when every rst_n_out bit is 1
busy  out  1  high while any output is still asserted
timeout_err  out  1  sticky; set when any stage timed out

Behaviour:
- reset high: rst_n_out=0 (all bits), all_released=0, busy=1, timeout_err=0, state=ASSERT, counters=0, sync chain all 1s. These values are asynchronous and take effect immediately, with no clock needed.
- Sync chain: on each clock the chain shifts in 0. rst_sync = last stage, so it deasserts SYNC_STAGES edges after reset falls.
- While rst_sync=1: FSM held in ASSERT, cnt=0.
- FSM states:
  - ASSERT: cnt increments each edge. At the edge where cnt==STRETCH_CYCLES-1: rst_n_out[0]<=1, idx<=0, cnt<=0. Then go to STEP if NUM_OUTPUTS>1, otherwise DONE.
  - STEP: cnt increments, saturating at TIMEOUT_CYCLES-1.
    - Release condition: (cnt>=STEP_CYCLES-1 and stage_ready[idx]) or cnt==TIMEOUT_CYCLES-1.
    - On release: rst_n_out[idx+1]<=1, idx++, cnt<=0.
    - If the release was caused by timeout: timeout_err<=1.
    - If idx+1==NUM_OUTPUTS-1, go to DONE.
  - DONE: hold outputs. stage_ready is ignored.
- Once released, outputs stay released until a reset or soft reset.
- soft_reset_req=1 at an edge (any state, including mid-ASSERT):
  - rst_n_out<=0 and timeout_err<=0 at that edge.
  - state<=ASSERT, cnt<=0, so ch0 releases STRETCH_CYCLES edges later.
  - Takes priority over a release at the same edge.
  - Held high: the sequence stays in ASSERT with cnt=0.
- Async reset mid-sequence: all outputs drop asynchronously and the full sequence restarts after deassert.
- all_released and busy are registered, decoded from the next-state value of rst_n_out, so they change on the same edge as rst_n_out. busy = ~all_released.
- No combinational path from any input to any output except the async reset.
- Counter width: clog2(max(STRETCH_CYCLES, TIMEOUT_CYCLES)+1). idx width: clog2(NUM_OUTPUTS)+1.

Decomposition:
- Package reset_seq_pkg: FSM state encoding (ASSERT, STEP, DONE) and a clog2 helper function.
- Sub-module reset_sync_chain (params SYNC_STAGES; ports clock, reset, rst_sync): async-assert, sync-deassert flop chain. It is instantiated once and is reusable elsewhere.

Test Plan:
1. Defaults, stage_ready=4'hF. Deassert reset before edge 1 -> rst_n_out[0] rises at edge 18, [1] at 26, [2] at 34, [3] at 42. all_released=1 and busy=0 at edge 42. timeout_err=0.
2. Defaults, stage_ready[1] held 0 -> ch1 at 26. ch2 is forced at 26+256=282 and timeout_err=1 at 282. ch3 at 290 if stage_ready[2]=1.
3. stage_ready[0] rises at edge 30 -> ch1 releases at edge 30 (STEP_CYCLES already satisfied), not 26.
4. After DONE, soft_reset_req pulsed at edge 100 -> rst_n_out=0, timeout_err=0, busy=1 from edge 100. ch0 rises at edge 116.
5. Async reset asserted mid-STEP between edges, with clock stopped -> rst_n_out=0 immediately. Sequence timings match scenario 1 after deassertion.
6. NUM_OUTPUTS=1, SYNC_STAGES=3, STRETCH_CYCLES=1 -> rst_n_out[0] and all_released rise at edge 4; stage_ready is ignored.
